// File: rtl/wicons_adc_stream_rx.sv
// Receiver for the W_ICONS serial recording stream: synchronizes CLK_REC/ADC_EN/ADC data,
// deserializes one word per ADC per frame and hands channel-tagged words out on valid/ready.
module wicons_adc_stream_rx #(
  parameter int ADC_RES_W      = 10,
  parameter int N_CH_PER_ADC_W = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      en_i,
  input  logic                      clk_rec_i,
  input  logic                      adc_en_i,
  input  logic                      adc1_dat_i,
  input  logic                      adc2_dat_i,
  output logic                      smp_valid_o,
  input  logic                      smp_ready_i,
  output logic [N_CH_PER_ADC_W:0]   smp_ch_o,
  output logic [ADC_RES_W-1:0]      smp_data_o,
  output logic                      err_frame_o,
  output logic                      err_ovf_o,
  input  logic                      err_clr_i
);

  localparam int BC_W = $clog2(ADC_RES_W + 1);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(ADC_RES_W);

  typedef enum logic [1:0] {F_IDLE, F_SHIFT, F_GAP} fstate_t;
  typedef enum logic [1:0] {O_EMPTY, O_OUT1, O_OUT2} ostate_t;

  // bit 0: CLK_REC, bit 1: ADC_EN, bit 2: ADC1_OUT, bit 3: ADC2_OUT
  logic [3:0] r_sync_s1;
  logic [3:0] r_sync_s2;
  logic       r_rec_q;

  fstate_t                    r_fst;
  logic [BC_W-1:0]            r_bitcnt;
  logic [ADC_RES_W-1:0]       r_sh1;
  logic [ADC_RES_W-1:0]       r_sh2;
  logic [N_CH_PER_ADC_W-1:0]  r_ch_cnt;

  ostate_t                    r_ost;
  logic                       r_valid;
  logic [N_CH_PER_ADC_W:0]    r_ch_out;
  logic [ADC_RES_W-1:0]       r_data_out;
  logic [N_CH_PER_ADC_W-1:0]  r_hold2_ch;
  logic [ADC_RES_W-1:0]       r_hold2_data;

  logic r_err_frame;
  logic r_err_ovf;

  logic w_rise;
  logic w_act;
  logic w_en;
  logic w_d1;
  logic w_d2;
  logic w_full;
  logic w_done;
  logic w_bad;
  logic w_hs;
  logic w_accept;
  logic w_drop;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sync_s1 <= '0;
      r_sync_s2 <= '0;
      r_rec_q   <= 1'b0;
    end else begin
      r_sync_s1 <= {adc2_dat_i, adc1_dat_i, adc_en_i, clk_rec_i};
      r_sync_s2 <= r_sync_s1;
      r_rec_q   <= r_sync_s2[0];
    end
  end

  assign w_rise = r_sync_s2[0] & ~r_rec_q;
  assign w_act  = w_rise & en_i;
  assign w_en   = r_sync_s2[1];
  assign w_d1   = r_sync_s2[2];
  assign w_d2   = r_sync_s2[3];
  assign w_full = (r_bitcnt == BC_FULL);

  assign w_done   = w_act & (r_fst == F_SHIFT) & ~w_en & w_full;
  // Too many bits (EN still high after a full word) or too few (EN dropped early).
  assign w_bad    = w_act & (r_fst == F_SHIFT) & (w_en ? w_full : ~w_full);
  assign w_hs     = r_valid & smp_ready_i;
  assign w_accept = w_done & ((r_ost == O_EMPTY) | ((r_ost == O_OUT2) & w_hs));
  assign w_drop   = w_done & ~w_accept;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_fst    <= F_IDLE;
      r_bitcnt <= '0;
      r_sh1    <= '0;
      r_sh2    <= '0;
      r_ch_cnt <= '0;
    end else if (!en_i) begin
      r_fst    <= F_IDLE;
      r_bitcnt <= '0;
      r_ch_cnt <= '0;
    end else if (w_rise) begin
      case (r_fst)
        F_IDLE: begin
          if (w_en) begin
            r_sh1    <= {{(ADC_RES_W-1){1'b0}}, w_d1};
            r_sh2    <= {{(ADC_RES_W-1){1'b0}}, w_d2};
            r_bitcnt <= BC_W'(1);
            r_fst    <= F_SHIFT;
          end
        end
        F_SHIFT: begin
          if (w_en) begin
            if (!w_full) begin
              r_sh1    <= {r_sh1[ADC_RES_W-2:0], w_d1};
              r_sh2    <= {r_sh2[ADC_RES_W-2:0], w_d2};
              r_bitcnt <= r_bitcnt + BC_W'(1);
            end else begin
              r_fst <= F_GAP;
            end
          end else begin
            // Good, short or dropped frames all consume one channel slot.
            r_ch_cnt <= r_ch_cnt + N_CH_PER_ADC_W'(1);
            r_fst    <= F_IDLE;
          end
        end
        F_GAP: begin
          if (!w_en) begin
            r_ch_cnt <= r_ch_cnt + N_CH_PER_ADC_W'(1);
            r_fst    <= F_IDLE;
          end
        end
        default: r_fst <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ost        <= O_EMPTY;
      r_valid      <= 1'b0;
      r_ch_out     <= '0;
      r_data_out   <= '0;
      r_hold2_ch   <= '0;
      r_hold2_data <= '0;
    end else begin
      case (r_ost)
        O_EMPTY: begin
          if (w_accept) begin
            r_valid      <= 1'b1;
            r_ch_out     <= {1'b0, r_ch_cnt};
            r_data_out   <= r_sh1;
            r_hold2_ch   <= r_ch_cnt;
            r_hold2_data <= r_sh2;
            r_ost        <= O_OUT1;
          end
        end
        O_OUT1: begin
          if (w_hs) begin
            r_ch_out   <= {1'b1, r_hold2_ch};
            r_data_out <= r_hold2_data;
            r_ost      <= O_OUT2;
          end
        end
        O_OUT2: begin
          // A frame finishing on the last handshake goes straight out without a bubble.
          if (w_accept) begin
            r_valid      <= 1'b1;
            r_ch_out     <= {1'b0, r_ch_cnt};
            r_data_out   <= r_sh1;
            r_hold2_ch   <= r_ch_cnt;
            r_hold2_data <= r_sh2;
            r_ost        <= O_OUT1;
          end else if (w_hs) begin
            r_valid <= 1'b0;
            r_ost   <= O_EMPTY;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ost   <= O_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err_frame <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      if (w_bad)          r_err_frame <= 1'b1;
      else if (err_clr_i) r_err_frame <= 1'b0;
      if (w_drop)         r_err_ovf   <= 1'b1;
      else if (err_clr_i) r_err_ovf   <= 1'b0;
    end
  end

  assign smp_valid_o = r_valid;
  assign smp_ch_o    = r_ch_out;
  assign smp_data_o  = r_data_out;
  assign err_frame_o = r_err_frame;
  assign err_ovf_o   = r_err_ovf;

endmodule

// File: tb/tb_wicons_adc_stream_rx.sv
// Directed bench for wicons_adc_stream_rx: drives CLK_REC at clk/4 and checks words, channels and flags.
module tb_wicons_adc_stream_rx;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       en_i = 1'b1;
  logic       clk_rec_i = 1'b0;
  logic       adc_en_i = 1'b0;
  logic       adc1_dat_i = 1'b0;
  logic       adc2_dat_i = 1'b0;
  logic       smp_valid_o;
  logic       smp_ready_i = 1'b1;
  logic [5:0] smp_ch_o;
  logic [9:0] smp_data_o;
  logic       err_frame_o;
  logic       err_ovf_o;
  logic       err_clr_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] rx_q[$];

  wicons_adc_stream_rx #(.ADC_RES_W(10), .N_CH_PER_ADC_W(5)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .en_i        (en_i),
    .clk_rec_i   (clk_rec_i),
    .adc_en_i    (adc_en_i),
    .adc1_dat_i  (adc1_dat_i),
    .adc2_dat_i  (adc2_dat_i),
    .smp_valid_o (smp_valid_o),
    .smp_ready_i (smp_ready_i),
    .smp_ch_o    (smp_ch_o),
    .smp_data_o  (smp_data_o),
    .err_frame_o (err_frame_o),
    .err_ovf_o   (err_ovf_o),
    .err_clr_i   (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Handshake seen at negedge completes on the following posedge.
  always @(negedge clk_i) begin
    if (smp_valid_o && smp_ready_i) begin
      rx_q.push_back({smp_ch_o, smp_data_o});
      $display("rx word ch=%0d data=0x%03h", smp_ch_o, smp_data_o);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_word(input int idx, input logic [5:0] ch, input logic [9:0] d, input string tag);
    logic [15:0] w;
    if (rx_q.size() > idx) begin
      w = rx_q[idx];
      check_val($sformatf("%s_ch%0d", tag, idx), 32'(w[15:10]), 32'(ch));
      check_val($sformatf("%s_dat%0d", tag, idx), 32'(w[9:0]), 32'(d));
    end else begin
      check_val($sformatf("%s_missing%0d", tag, idx), 32'(rx_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic rec_cycle(input logic en, input logic b1, input logic b2);
    clk_rec_i = 1'b0; adc_en_i = en; adc1_dat_i = b1; adc2_dat_i = b2;
    repeat (2) @(posedge clk_i); #1;
    clk_rec_i = 1'b1;
    repeat (2) @(posedge clk_i); #1;
  endtask

  task automatic send_bits(input int n, input logic [9:0] w1, input logic [9:0] w2);
    for (int i = 0; i < n; i++) begin
      if (i < 10) rec_cycle(1'b1, w1[9-i], w2[9-i]);
      else        rec_cycle(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input int n, input logic [9:0] w1, input logic [9:0] w2);
    send_bits(n, w1, w2);
    rec_cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Leaves CLK_REC freshly raised with ADC_EN low; caller counts the following edges.
  task automatic term_start();
    clk_rec_i = 1'b0; adc_en_i = 1'b0; adc1_dat_i = 1'b0; adc2_dat_i = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    clk_rec_i = 1'b1;
  endtask

  task automatic en_pulse();
    en_i = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    en_i = 1'b1;
  endtask

  task automatic clr_pulse();
    err_clr_i = 1'b1;
    @(posedge clk_i); #1;
    err_clr_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk_i); #1;
    check_val("rst_valid_in", 32'(smp_valid_o), 32'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check_val("rst_valid", 32'(smp_valid_o), 32'd0);
    check_val("rst_ch", 32'(smp_ch_o), 32'd0);
    check_val("rst_data", 32'(smp_data_o), 32'd0);
    check_val("rst_errf", 32'(err_frame_o), 32'd0);
    check_val("rst_erro", 32'(err_ovf_o), 32'd0);

    // Single frame with latency measurement
    send_bits(10, 10'h2A5, 10'h15A);
    term_start();
    @(posedge clk_i); #1; check_val("lat_c1", 32'(smp_valid_o), 32'd0);
    @(posedge clk_i); #1; check_val("lat_c2", 32'(smp_valid_o), 32'd0);
    @(posedge clk_i); #1; check_val("lat_c3", 32'(smp_valid_o), 32'd1);
    repeat (6) @(posedge clk_i); #1;
    check_val("single_cnt", 32'(rx_q.size()), 32'd2);
    check_word(0, 6'd0, 10'h2A5, "single");
    check_word(1, 6'd32, 10'h15A, "single");
    check_val("single_errf", 32'(err_frame_o), 32'd0);
    check_val("single_erro", 32'(err_ovf_o), 32'd0);

    // Scan wrap over 33 frames
    en_pulse();
    rx_q.delete();
    for (int n = 0; n < 33; n++) send_frame(10, 10'(n), 10'(n + 'h100));
    repeat (8) @(posedge clk_i); #1;
    check_val("wrap_cnt", 32'(rx_q.size()), 32'd66);
    for (int n = 0; n < 33; n++) begin
      check_word(2*n, 6'(n % 32), 10'(n), "wrap");
      check_word(2*n + 1, 6'(32 + n % 32), 10'(n + 'h100), "wrap");
    end

    // Backpressure: second pair dropped
    en_pulse();
    rx_q.delete();
    smp_ready_i = 1'b0;
    send_frame(10, 10'h011, 10'h022);
    repeat (4) @(posedge clk_i); #1;
    check_val("bp_valid", 32'(smp_valid_o), 32'd1);
    check_val("bp_data_a", 32'(smp_data_o), 32'h011);
    send_frame(10, 10'h033, 10'h044);
    repeat (4) @(posedge clk_i); #1;
    check_val("bp_hold_ch", 32'(smp_ch_o), 32'd0);
    check_val("bp_hold_data", 32'(smp_data_o), 32'h011);
    check_val("bp_ovf", 32'(err_ovf_o), 32'd1);
    smp_ready_i = 1'b1;
    repeat (6) @(posedge clk_i); #1;
    check_val("bp_cnt", 32'(rx_q.size()), 32'd2);
    check_word(0, 6'd0, 10'h011, "bp");
    check_word(1, 6'd32, 10'h022, "bp");
    send_frame(10, 10'h055, 10'h066);
    repeat (6) @(posedge clk_i); #1;
    check_word(2, 6'd2, 10'h055, "bp");
    check_word(3, 6'd34, 10'h066, "bp");
    clr_pulse();
    check_val("bp_clr", 32'(err_ovf_o), 32'd0);

    // Framing errors: short, long, then good
    en_pulse();
    rx_q.delete();
    send_frame(8, 10'h3FF, 10'h3FF);
    send_frame(12, 10'h3FF, 10'h3FF);
    repeat (4) @(posedge clk_i); #1;
    check_val("frm_errf", 32'(err_frame_o), 32'd1);
    check_val("frm_none", 32'(rx_q.size()), 32'd0);
    send_frame(10, 10'h155, 10'h0AA);
    repeat (6) @(posedge clk_i); #1;
    check_val("frm_cnt", 32'(rx_q.size()), 32'd2);
    check_word(0, 6'd2, 10'h155, "frm");
    check_word(1, 6'd34, 10'h0AA, "frm");
    check_val("frm_erro", 32'(err_ovf_o), 32'd0);
    clr_pulse();
    check_val("frm_clr", 32'(err_frame_o), 32'd0);

    // Frame completes on the same edge as the OUT2 handshake
    en_pulse();
    rx_q.delete();
    smp_ready_i = 1'b0;
    send_frame(10, 10'h101, 10'h202);
    repeat (4) @(posedge clk_i); #1;
    send_bits(10, 10'h303, 10'h004);
    term_start();
    @(posedge clk_i); #1; smp_ready_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    check_val("bnd_valid", 32'(smp_valid_o), 32'd1);
    check_val("bnd_ch", 32'(smp_ch_o), 32'd1);
    check_val("bnd_data", 32'(smp_data_o), 32'h303);
    check_val("bnd_erro", 32'(err_ovf_o), 32'd0);
    repeat (6) @(posedge clk_i); #1;
    check_val("bnd_cnt", 32'(rx_q.size()), 32'd4);
    check_word(0, 6'd0, 10'h101, "bnd");
    check_word(1, 6'd32, 10'h202, "bnd");
    check_word(2, 6'd1, 10'h303, "bnd");
    check_word(3, 6'd33, 10'h004, "bnd");

    // Clear coincident with a new framing error
    send_bits(8, 10'h0FF, 10'h0FF);
    term_start();
    @(posedge clk_i);
    @(posedge clk_i); #1; err_clr_i = 1'b1;
    @(posedge clk_i); #1;
    check_val("clrset_errf", 32'(err_frame_o), 32'd1);
    err_clr_i = 1'b0;
    @(posedge clk_i); #1;
    check_val("clrset_hold", 32'(err_frame_o), 32'd1);
    clr_pulse();

    // Reset mid-drain and mid-frame
    rx_q.delete();
    smp_ready_i = 1'b0;
    send_frame(10, 10'h3C3, 10'h111);
    repeat (4) @(posedge clk_i); #1;
    check_val("rstm_pre", 32'(smp_valid_o), 32'd1);
    send_bits(5, 10'h2AA, 10'h155);
    reset_n_i = 1'b0;
    #1;
    check_val("rstm_valid", 32'(smp_valid_o), 32'd0);
    check_val("rstm_ch", 32'(smp_ch_o), 32'd0);
    check_val("rstm_data", 32'(smp_data_o), 32'd0);
    repeat (2) @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    smp_ready_i = 1'b1;
    rx_q.delete();
    rec_cycle(1'b1, 1'b0, 1'b1);
    rec_cycle(1'b1, 1'b1, 1'b0);
    rec_cycle(1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk_i); #1;
    check_val("rstm_noemit", 32'(rx_q.size()), 32'd0);
    check_val("rstm_errf", 32'(err_frame_o), 32'd1);
    clr_pulse();

    // Enable dropped mid-frame restarts channel numbering
    rx_q.delete();
    send_frame(10, 10'h0F0, 10'h00F);
    send_bits(5, 10'h3FF, 10'h3FF);
    en_i = 1'b0;
    rec_cycle(1'b1, 1'b1, 1'b1);
    rec_cycle(1'b0, 1'b0, 1'b0);
    en_i = 1'b1;
    rec_cycle(1'b0, 1'b0, 1'b0);
    send_frame(10, 10'h123, 10'h321);
    repeat (6) @(posedge clk_i); #1;
    check_val("en_cnt", 32'(rx_q.size()), 32'd4);
    check_word(0, 6'd1, 10'h0F0, "en");
    check_word(1, 6'd33, 10'h00F, "en");
    check_word(2, 6'd0, 10'h123, "en");
    check_word(3, 6'd32, 10'h321, "en");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
